// File: rtl/i_mem_fill_ctrl_pkg.sv
// Shared types and defaults for the instruction memory fill engine.
// The cache-side request/response structs are the same ones the IFU cache uses.
package i_mem_fill_ctrl_pkg;

  localparam int I_MEM_WORDS        = 4096;
  localparam int I_MEM_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE,
    LATENCY,
    READ,
    RESP
  } t_i_mem_fill_states;

  typedef struct packed {
    logic        fill_requested_address_valid;
    logic [31:0] fill_requested_address;
  } t_cache2i_mem_req;

  typedef struct packed {
    logic         valid;
    logic [31:0]  address;
    logic [127:0] filled_instruction;
  } t_i_mem2cache_rsp;

endpackage

// File: rtl/i_mem_fill_ctrl_array.sv
// Word-wide instruction store: one combinational read port, one clocked write port.
// Contents are deliberately not reset so the array can map onto LUTRAM/BRAM.
module i_mem_fill_ctrl_array #(
  parameter int MEM_WORDS = 4096,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [31:0]      i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Async read means a same-edge write is seen only from the next cycle on.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/i_mem_fill_ctrl.sv
// Cache-line fill engine: accepts a fill request, waits READ_LATENCY cycles, reads
// four words into a line buffer and presents the line with a single valid pulse.
module i_mem_fill_ctrl
  import i_mem_fill_ctrl_pkg::*;
#(
  parameter int MEM_WORDS    = I_MEM_WORDS,
  parameter int READ_LATENCY = I_MEM_READ_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  t_cache2i_mem_req cache2i_mem_req,
  output t_i_mem2cache_rsp i_mem2cache_rsp,
  input  logic             load_we,
  input  logic [31:0]      load_addr,
  input  logic [31:0]      load_data,
  output logic             busy,
  output logic             req_dropped
);

  localparam int         IDX_W    = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_LAST = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

  t_i_mem_fill_states r_state;
  t_i_mem_fill_states w_next_state;
  logic               w_req;
  logic               w_accept;
  logic [3:0]         r_lat_cnt;
  logic [1:0]         r_word_cnt;
  logic [31:0]        r_base;
  logic [95:0]        r_line;
  t_i_mem2cache_rsp   r_rsp;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [31:0]        w_rd_data;
  logic               w_unused_addr_bits;

  assign w_req = cache2i_mem_req.fill_requested_address_valid;

  // The line base has bits [3:2] clear, so OR-ing in the word counter walks the line.
  assign w_rd_idx = r_base[IDX_W+1:2] | IDX_W'(r_word_cnt);
  assign w_wr_idx = load_addr[IDX_W+1:2];

  assign w_unused_addr_bits = ^{load_addr[1:0], load_addr[31:IDX_W+2],
                                cache2i_mem_req.fill_requested_address[3:0]};

  i_mem_fill_ctrl_array #(
    .MEM_WORDS(MEM_WORDS),
    .IDX_W    (IDX_W)
  ) u_array (
    .clk    (clk),
    .i_we   (load_we),
    .i_waddr(w_wr_idx),
    .i_wdata(load_data),
    .i_raddr(w_rd_idx),
    .o_rdata(w_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept     = 1'b1;
          w_next_state = (READ_LATENCY > 0) ? LATENCY : READ;
        end
      end
      LATENCY: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_next_state = READ;
        end
      end
      READ: begin
        if (r_word_cnt == 2'd3) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Response fields are only rewritten when a line completes, so they hold for the
  // cache to latch one cycle after the valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat_cnt  <= 4'd0;
      r_word_cnt <= 2'd0;
      r_base     <= 32'd0;
      r_line     <= 96'd0;
      r_rsp      <= '0;
    end else begin
      r_rsp.valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_base     <= {cache2i_mem_req.fill_requested_address[31:4], 4'b0000};
            r_word_cnt <= 2'd0;
            r_lat_cnt  <= 4'd0;
          end
        end
        LATENCY: begin
          r_lat_cnt <= r_lat_cnt + 4'd1;
        end
        READ: begin
          r_word_cnt <= r_word_cnt + 2'd1;
          case (r_word_cnt)
            2'd0: r_line[31:0]  <= w_rd_data;
            2'd1: r_line[63:32] <= w_rd_data;
            2'd2: r_line[95:64] <= w_rd_data;
            default: begin
              r_rsp.valid              <= 1'b1;
              r_rsp.address            <= r_base;
              r_rsp.filled_instruction <= {w_rd_data, r_line};
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

  assign i_mem2cache_rsp = r_rsp;
  assign busy            = (r_state != IDLE);
  assign req_dropped     = w_req && (r_state != IDLE);

endmodule

// File: tb/tb_i_mem_fill_ctrl.sv
// Scoreboard bench for i_mem_fill_ctrl: one instance at the default latency and one
// with zero latency, sharing the loader port and reset.
module tb_i_mem_fill_ctrl;
  import i_mem_fill_ctrl_pkg::*;

  localparam int WORDS = 4096;

  typedef struct {
    int           cyc;
    logic [31:0]  addr;
    logic [127:0] data;
  } expT;

  logic             clk = 1'b0;
  logic             rst;
  t_cache2i_mem_req reqA, reqB;
  t_i_mem2cache_rsp rspA, rspB;
  logic             loadWe;
  logic [31:0]      loadAddr, loadData;
  logic             busyA, busyB, dropA, dropB;

  expT         qA[$];
  expT         qB[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] model [WORDS];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i_mem_fill_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cache2i_mem_req(reqA),
    .i_mem2cache_rsp(rspA),
    .load_we        (loadWe),
    .load_addr      (loadAddr),
    .load_data      (loadData),
    .busy           (busyA),
    .req_dropped    (dropA)
  );

  i_mem_fill_ctrl #(.MEM_WORDS(WORDS), .READ_LATENCY(0)) dutZero (
    .clk            (clk),
    .rst            (rst),
    .cache2i_mem_req(reqB),
    .i_mem2cache_rsp(rspB),
    .load_we        (loadWe),
    .load_addr      (loadAddr),
    .load_data      (loadData),
    .busy           (busyB),
    .req_dropped    (dropB)
  );

  task automatic checkOutput(input string tag, input logic [160:0] got, input logic [160:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] lineOf(input logic [31:0] addr);
    logic [127:0] line;
    int           w;
    line = '0;
    for (int k = 0; k < 4; k++) begin
      w = (int'(addr[31:4]) * 4 + k) % WORDS;
      line[32*k +: 32] = model[w];
    end
    return line;
  endfunction

  always @(negedge clk) begin : monA
    expT e;
    if (rst && rspA.valid === 1'b1) begin
      if (qA.size() == 0) begin
        checkOutput("unexpectedValidA", 161'(rspA.valid), 161'd0);
      end else begin
        e = qA.pop_front();
        checkOutput("cycleA", 161'(cyc), 161'(e.cyc));
        checkOutput("addrA", 161'(rspA.address), 161'(e.addr));
        checkOutput("dataA", 161'(rspA.filled_instruction), 161'(e.data));
      end
    end
  end

  always @(negedge clk) begin : monB
    expT e;
    if (rst && rspB.valid === 1'b1) begin
      if (qB.size() == 0) begin
        checkOutput("unexpectedValidB", 161'(rspB.valid), 161'd0);
      end else begin
        e = qB.pop_front();
        checkOutput("cycleB", 161'(cyc), 161'(e.cyc));
        checkOutput("addrB", 161'(rspB.address), 161'(e.addr));
        checkOutput("dataB", 161'(rspB.filled_instruction), 161'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request cycle; an accepted request pushes its expected response.
  task automatic applyStimulus(input bit toZero, input logic [31:0] addr, input bit accept,
                               input logic [127:0] expData);
    expT e;
    if (toZero) reqB = '{1'b1, addr};
    else        reqA = '{1'b1, addr};
    if (accept) begin
      e.cyc  = cyc + (toZero ? 5 : 7);
      e.addr = {addr[31:4], 4'b0000};
      e.data = expData;
      if (toZero) qB.push_back(e);
      else        qA.push_back(e);
    end
    @(negedge clk);
    if (toZero) checkOutput("droppedB", 161'(dropB), 161'(!accept));
    else        checkOutput("droppedA", 161'(dropA), 161'(!accept));
    tick();
    reqA = '0;
    reqB = '0;
  endtask

  task automatic loadWord(input int idx, input logic [31:0] data);
    loadWe   = 1'b1;
    loadAddr = 32'(idx * 4);
    loadData = data;
    tick();
    loadWe   = 1'b0;
    model[idx] = data;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && (qA.size() != 0 || qB.size() != 0); i++) tick();
    checkOutput("drainA", 161'(qA.size()), 161'd0);
    checkOutput("drainB", 161'(qB.size()), 161'd0);
  endtask

  initial begin
    rst      = 1'b0;
    reqA     = '0;
    reqB     = '0;
    loadWe   = 1'b0;
    loadAddr = '0;
    loadData = '0;
    for (int i = 0; i < WORDS; i++) model[i] = 32'h0;
    tick();
    tick();
    checkOutput("resetRspA", 161'(rspA), 161'd0);
    checkOutput("resetBusyA", 161'(busyA), 161'd0);
    checkOutput("resetDropA", 161'(dropA), 161'd0);
    checkOutput("resetRspB", 161'(rspB), 161'd0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) loadWord(i, 32'h1000_0000 + i);

    // Basic fill of line 1, then the response must hold after the pulse.
    applyStimulus(0, 32'h0000_0014, 1,
                  {32'h1000_0007, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004});
    waitDrain();
    tick();
    tick();
    checkOutput("holdValid", 161'(rspA.valid), 161'd0);
    checkOutput("holdAddr", 161'(rspA.address), 161'h10);
    checkOutput("holdData", 161'(rspA.filled_instruction),
                161'({32'h1000_0007, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004}));

    // Requests right after accept and in the RESP cycle are both dropped.
    applyStimulus(0, 32'h0000_0020, 1, lineOf(32'h20));
    checkOutput("busyAfterAccept", 161'(busyA), 161'd1);
    applyStimulus(0, 32'h0000_0040, 0, '0);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(0, 32'h0000_0080, 0, '0);
    waitDrain();
    checkOutput("captureKept", 161'(rspA.address), 161'h20);

    // Loader write to word 2 lands before word 2 is read.
    model[2] = 32'hDEAD_BEEF;
    applyStimulus(0, 32'h0000_0000, 1, lineOf(32'h0));
    tick();
    tick();
    tick();
    loadWord(2, 32'hDEAD_BEEF);
    waitDrain();
    checkOutput("patchedWord2", 161'(rspA.filled_instruction[95:64]), 161'h0DEAD_BEEF);

    // Write to word 1 in the same cycle it is read returns the old word.
    applyStimulus(0, 32'h0000_0000, 1, lineOf(32'h0));
    tick();
    tick();
    tick();
    loadWord(1, 32'hCAFE_0001);
    waitDrain();
    checkOutput("oldWord1", 161'(rspA.filled_instruction[63:32]), 161'h1000_0001);
    applyStimulus(0, 32'h0000_0004, 1, lineOf(32'h0));
    waitDrain();
    checkOutput("newWord1", 161'(rspA.filled_instruction[63:32]), 161'hCAFE_0001);

    // Reset mid-fill aborts with no pulse and clears the response at once.
    applyStimulus(0, 32'h0000_0030, 1, lineOf(32'h30));
    tick();
    tick();
    rst = 1'b0;
    qA.delete();
    #1;
    checkOutput("abortBusy", 161'(busyA), 161'd0);
    checkOutput("abortRsp", 161'(rspA), 161'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("noPulseAfterAbort", 161'(rspA.valid), 161'd0);
    applyStimulus(0, 32'h0000_0030, 1, lineOf(32'h30));
    waitDrain();

    // Zero latency with an address beyond the array wraps onto words 8..11.
    applyStimulus(1, WORDS * 4 + 32'h20, 1,
                  {32'h1000_000B, 32'h1000_000A, 32'h1000_0009, 32'h1000_0008});
    waitDrain();
    checkOutput("wrapAddr", 161'(rspB.address), 161'(WORDS * 4 + 32'h20));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
